// File: rtl/lm07_pkg.sv
// Shared types and constants for the LM07 temperature-sensor reader.
`timescale 1ns/1ps
package lm07_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } lm07_state_e;

    localparam int FRAME_BITS_DEF = 16;
    localparam int SHREG_W        = 16;
    // Integer-temperature byte inside the received word
    localparam int TEMP_HI        = 15;
    localparam int TEMP_LO        = 8;

endpackage

// File: rtl/lm07_sck_gen.sv
// SCK divider: counts half-periods while enabled and toggles SCK when allowed,
// flagging the cycle in which SCK will rise or fall at the next edge.
`timescale 1ns/1ps
module lm07_sck_gen #(
    parameter int HALF_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic toggle_en,
    output logic sck,
    output logic half_s,
    output logic rise_s,
    output logic fall_s
);

    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] div_r;
    logic             sck_r;

    assign half_s = en && (div_r == DIV_LAST);
    assign rise_s = half_s && toggle_en && !sck_r;
    assign fall_s = half_s && toggle_en && sck_r;
    assign sck    = sck_r;

    // Half-period divider and SCK toggle register; idles low when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= '0;
            sck_r <= 1'b0;
        end else if (!en) begin
            div_r <= '0;
            sck_r <= 1'b0;
        end else begin
            if (half_s) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            if (half_s && toggle_en) begin
                sck_r <= ~sck_r;
            end else begin
                sck_r <= sck_r;
            end
        end
    end

endmodule

// File: rtl/lm07_read.sv
// LM07 3-wire reader: frames CS, clocks 16 bits in on SIO, latches the integer
// temperature byte and multiplexes two hex digits onto a 7-segment display.
`timescale 1ns/1ps
module lm07_read
    import lm07_pkg::*;
#(
    parameter int HALF_DIV   = 1,
    parameter int FRAME_BITS = FRAME_BITS_DEF,
    parameter int GAP_CYCLES = 4,
    parameter int REFRESH_W  = 4
) (
    input  logic       SYSCLK,
    input  logic       RSTN,
    input  logic       SIO,
    output logic       CS,
    output logic       SEL0,
    output logic       SEL1,
    output logic       SCK,
    output logic [7:0] data_latched,
    output logic [3:0] displayLSB,
    output logic [3:0] displayMSB
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam int BIT_W = $clog2(FRAME_BITS + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS);

    lm07_state_e          state_r;
    lm07_state_e          state_next;
    logic [GAP_W-1:0]     gap_r;
    logic [BIT_W-1:0]     bitcnt_r;
    logic [SHREG_W-1:0]   shreg_r;
    logic [7:0]           data_latched_r;
    logic                 cs_r;
    logic                 sel0_r;
    logic                 sel1_r;
    logic [REFRESH_W-1:0] refresh_r;
    logic                 sck_en_s;
    logic                 sck_tog_s;
    logic                 sck_s;
    logic                 half_s;
    logic                 rise_s;
    logic                 fall_s;

    lm07_sck_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sck_gen (
        .clk       (SYSCLK),
        .rst       (RSTN),
        .en        (sck_en_s),
        .toggle_en (sck_tog_s),
        .sck       (sck_s),
        .half_s    (half_s),
        .rise_s    (rise_s),
        .fall_s    (fall_s)
    );

    // Next-state decode; the divider runs through SETUP so its half-period times CS lead-in
    always_comb begin
        state_next = state_r;
        sck_en_s   = 1'b0;
        sck_tog_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gap_r == GAP_LAST) begin
                    state_next = ST_SETUP;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SETUP: begin
                sck_en_s = 1'b1;
                if (half_s) begin
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                sck_en_s  = 1'b1;
                sck_tog_s = 1'b1;
                if (fall_s && (bitcnt_r == BIT_LAST)) begin
                    state_next = ST_LATCH;
                end else begin
                    state_next = ST_SHIFT;
                end
            end
            ST_LATCH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge SYSCLK or posedge RSTN) begin
        if (RSTN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Inter-frame gap counter, only advancing while idle
    always_ff @(posedge SYSCLK or posedge RSTN) begin
        if (RSTN) begin
            gap_r <= '0;
        end else if (state_r == ST_IDLE) begin
            if (gap_r == GAP_LAST) begin
                gap_r <= '0;
            end else begin
                gap_r <= gap_r + GAP_W'(1);
            end
        end else begin
            gap_r <= '0;
        end
    end

    // Receive path: SIO is sampled at the edge where SCK goes high
    always_ff @(posedge SYSCLK or posedge RSTN) begin
        if (RSTN) begin
            bitcnt_r <= '0;
            shreg_r  <= '0;
        end else if (state_r == ST_SETUP) begin
            bitcnt_r <= '0;
            shreg_r  <= shreg_r;
        end else if (rise_s) begin
            bitcnt_r <= bitcnt_r + BIT_W'(1);
            shreg_r  <= {shreg_r[SHREG_W-2:0], SIO};
        end else begin
            bitcnt_r <= bitcnt_r;
            shreg_r  <= shreg_r;
        end
    end

    // Result latch, written only once a complete frame has been shifted in
    always_ff @(posedge SYSCLK or posedge RSTN) begin
        if (RSTN) begin
            data_latched_r <= 8'h00;
        end else if (state_r == ST_LATCH) begin
            data_latched_r <= shreg_r[TEMP_HI:TEMP_LO];
        end else begin
            data_latched_r <= data_latched_r;
        end
    end

    // Chip select, registered from the next state so it aligns with the FSM
    always_ff @(posedge SYSCLK or posedge RSTN) begin
        if (RSTN) begin
            cs_r <= 1'b1;
        end else begin
            cs_r <= !((state_next == ST_SETUP) || (state_next == ST_SHIFT));
        end
    end

    // Digit refresh: the two selects swap on every counter wrap
    always_ff @(posedge SYSCLK or posedge RSTN) begin
        if (RSTN) begin
            refresh_r <= '0;
            sel0_r    <= 1'b1;
            sel1_r    <= 1'b0;
        end else begin
            refresh_r <= refresh_r + REFRESH_W'(1);
            if (refresh_r == {REFRESH_W{1'b1}}) begin
                sel0_r <= sel1_r;
                sel1_r <= sel0_r;
            end else begin
                sel0_r <= sel0_r;
                sel1_r <= sel1_r;
            end
        end
    end

    assign CS           = cs_r;
    assign SCK          = sck_s;
    assign SEL0         = sel0_r;
    assign SEL1         = sel1_r;
    assign data_latched = data_latched_r;
    assign displayLSB   = data_latched_r[3:0];
    assign displayMSB   = data_latched_r[7:4];

endmodule

// File: tb/tb_lm07_read.sv
// Directed bench for lm07_read with an inline LM07 sensor model (mode 0, MSB first).
`timescale 1ns/1ps
module tb_lm07_read;

    logic       sysclk = 1'b0;
    logic       rst;
    logic       sio = 1'b0;
    logic       cs;
    logic       sel0;
    logic       sel1;
    logic       sck;
    logic [7:0] data_latched;
    logic [3:0] display_lsb;
    logic [3:0] display_msb;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model_word = 16'h0000;
    int   model_idx  = 16;
    int   rise_cnt   = 0;
    int   last_rises = 0;
    int   frame_cnt  = 0;
    bit   started    = 1'b0;
    int   fall_cnt   = 0;
    time  first_fall_t = 0;
    time  prev_fall_t  = 0;
    time  last_fall_t  = 0;

    int   cyc          = 0;
    int   sel_equal    = 0;
    int   sck_viol     = 0;
    int   bad_interval = 0;
    int   toggles      = 0;
    int   last_toggle  = -1;
    logic prev_sel0    = 1'b1;

    logic [7:0] pre;
    int         tog_start;
    bit         found;

    always #5 sysclk = ~sysclk;

    lm07_read dut (
        .SYSCLK       (sysclk),
        .RSTN         (rst),
        .SIO          (sio),
        .CS           (cs),
        .SEL0         (sel0),
        .SEL1         (sel1),
        .SCK          (sck),
        .data_latched (data_latched),
        .displayLSB   (display_lsb),
        .displayMSB   (display_msb)
    );

    // Sensor model: first bit valid at CS fall, next bit presented after each SCK fall
    always @(negedge sck or negedge cs or posedge cs) begin
        if (cs !== 1'b0) begin
            model_idx = 16;
            sio = 1'b0;
        end else if (model_idx == 16) begin
            model_idx = 15;
            sio = model_word[15];
        end else if (model_idx > 0) begin
            model_idx = model_idx - 1;
            sio = model_word[model_idx];
        end
    end

    // SCK rises seen inside the current CS-low window
    always @(posedge sck or negedge cs) begin
        if (sck === 1'b1) begin
            if (cs === 1'b0) rise_cnt = rise_cnt + 1;
        end else begin
            rise_cnt = 0;
        end
    end

    always @(posedge cs) begin
        if (started) begin
            last_rises = rise_cnt;
            frame_cnt  = frame_cnt + 1;
        end
    end

    always @(negedge cs) begin
        fall_cnt    = fall_cnt + 1;
        prev_fall_t = last_fall_t;
        last_fall_t = $time;
        if (fall_cnt == 1) first_fall_t = $time;
    end

    // Continuous monitors sampled mid-cycle
    always @(negedge sysclk) begin
        cyc = cyc + 1;
        if (rst !== 1'b0) begin
            last_toggle = -1;
            prev_sel0   = 1'b1;
        end else begin
            if (sel0 === sel1) sel_equal = sel_equal + 1;
            if (cs === 1'b1 && sck !== 1'b0) sck_viol = sck_viol + 1;
            if (sel0 !== prev_sel0) begin
                if (last_toggle >= 0 && (cyc - last_toggle) != 16) bad_interval = bad_interval + 1;
                last_toggle = cyc;
                toggles = toggles + 1;
            end
            prev_sel0 = sel0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next frame's CS rise, return data_latched before the latch edge, then step past it
    task automatic wait_frame(input string tag, output logic [7:0] pre_val);
        int start;
        bit seen;
        start = frame_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 120 && !seen; i++) begin
            @(posedge sysclk);
            #1;
            if (frame_cnt != start) seen = 1'b1;
        end
        chk({tag, "_frame_seen"}, 32'(seen), 32'd1);
        pre_val = data_latched;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        #2;
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sck", 32'(sck), 32'd0);
        chk("rst_data", 32'(data_latched), 32'h0);
        chk("rst_msb", 32'(display_msb), 32'h0);
        chk("rst_sel0", 32'(sel0), 32'd1);
        chk("rst_sel1", 32'(sel1), 32'd0);

        model_word = 16'h1980;
        #10;
        rst = 1'b0;
        started = 1'b1;

        // Frame 1: 0x1980
        wait_frame("f1", pre);
        chk("f1_first_cs_fall_t", 32'(first_fall_t), 32'd45);
        chk("f1_rises", 32'(last_rises), 32'd16);
        chk("f1_data", 32'(data_latched), 32'h19);
        chk("f1_msb", 32'(display_msb), 32'h1);
        chk("f1_lsb", 32'(display_lsb), 32'h9);

        // Frame 2: word changed during the gap; old value held until the latch edge
        model_word = 16'h2000;
        wait_frame("f2", pre);
        chk("f2_pre_latch", 32'(pre), 32'h19);
        chk("f2_data", 32'(data_latched), 32'h20);
        chk("f2_rises", 32'(last_rises), 32'd16);
        chk("f2_period", 32'(last_fall_t - prev_fall_t), 32'd380);

        // Frame 3: negative reading
        model_word = 16'hE7FF;
        wait_frame("f3", pre);
        chk("f3_pre_latch", 32'(pre), 32'h20);
        chk("f3_data", 32'(data_latched), 32'hE7);
        chk("f3_msb", 32'(display_msb), 32'hE);
        chk("f3_lsb", 32'(display_lsb), 32'h7);
        chk("f3_rises", 32'(last_rises), 32'd16);

        // Abort after 8 bits of the next frame
        model_word = 16'h5A00;
        found = 1'b0;
        for (int i = 0; i < 120 && !found; i++) begin
            @(posedge sysclk);
            #1;
            if (cs === 1'b0 && rise_cnt == 8) found = 1'b1;
        end
        chk("abort_bit8_seen", 32'(found), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_sck", 32'(sck), 32'd0);
        chk("abort_data", 32'(data_latched), 32'h0);
        #20;
        rst = 1'b0;
        wait_frame("f4", pre);
        chk("f4_pre_latch", 32'(pre), 32'h0);
        chk("f4_data", 32'(data_latched), 32'h5A);
        chk("f4_msb", 32'(display_msb), 32'h5);
        chk("f4_lsb", 32'(display_lsb), 32'hA);
        chk("f4_rises", 32'(last_rises), 32'd16);

        // Display refresh over 1000 ns
        tog_start = toggles;
        repeat (100) @(posedge sysclk);
        #1;
        chk("sel_toggles_1000ns", 32'((toggles - tog_start) == 6 || (toggles - tog_start) == 7), 32'd1);
        chk("sel_interval", 32'(bad_interval), 32'd0);
        chk("sel_never_equal", 32'(sel_equal), 32'd0);
        chk("sck_low_when_cs_high", 32'(sck_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
